fpu_align_shift32: RTL and testbench
====================================

FPU_ALIGN_SHIFT32 -- requirements
Module: fpu_align_shift32

Interface
REQ-001 SHALL have parameter WID, default 32, meaning operand width; only 32 is supported.
REQ-002 SHALL have parameter SHW, default 6, meaning shift-amount width, covering 0..63.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ld_i, input, 1 bit: input valid.
REQ-006 SHALL have port rdy_o, output, 1 bit: input ready; a transfer occurs when ld_i & rdy_o.
REQ-007 SHALL have port a_i, input, 6 bits: right-shift amount.
REQ-008 SHALL have port b_i, input, 32 bits: mantissa to align.
REQ-009 SHALL have port tag_i, input, 4 bits: caller tag, carried through unchanged.
REQ-010 SHALL have port vld_o, output, 1 bit: result valid.
REQ-011 SHALL have port ack_i, input, 1 bit: downstream accept; a result is consumed when vld_o & ack_i.
REQ-012 SHALL have port o_o, output, 32 bits: b_i >> a_i (logical shift).
REQ-013 SHALL have port sticky_o, output, 1 bit: OR of all bits shifted out.
REQ-014 SHALL have port tag_o, output, 4 bits: tag of the result.

Function
REQ-015 SHALL be a two-stage pipeline, S1 (capture) then S2 (shift and sticky), each stage holding a valid bit.
REQ-016 SHALL present a result on vld_o/o_o/sticky_o/tag_o exactly 2 cycles after its accepted transfer when there is no backpressure.
REQ-017 SHALL sustain a throughput of one transfer per cycle while ack_i is held high.
REQ-018 SHALL drive rdy_o = !s1_v | !s2_v | ack_i; rdy_o SHALL be combinational from state and ack_i only, never from ld_i.
REQ-019 SHALL advance S1 into S2 when s1_v & (!s2_v | ack_i).
REQ-020 SHALL clear s2_v on consume when S1 is empty.
REQ-021 SHALL load S1 on a transfer; otherwise S1 SHALL clear when it advances and SHALL hold otherwise.
REQ-022 SHALL, on a simultaneous consume, advance and load in one cycle, perform all three with no bubble and no data loss.
REQ-023 SHALL hold o_o, sticky_o and tag_o stable while vld_o=1 and ack_i=0.
REQ-024 SHALL, for a=0, produce o=b and sticky=0.
REQ-025 SHALL, for 1<=a<=31, produce o=b>>a and sticky = OR of b[a-1:0].
REQ-026 SHALL, for a>=32, produce o=0 and sticky = OR of b[31:0].
REQ-027 SHALL compute sticky through the prefix-OR sub-module, with index a-1 clamped to 31 and forced to 0 when a=0.
REQ-028 SHALL drive outputs whose vld_o=0 as don't-care; the bench SHALL NOT check them.

Reset
REQ-029 SHALL, while rst_i=1 at a clock edge, clear s1_v and s2_v, giving vld_o=0 the next cycle.
REQ-030 SHALL reset o_o, sticky_o and tag_o to 0.
REQ-031 SHALL drive rdy_o=1 from the first cycle after reset.
REQ-032 SHALL discard any in-flight operation when reset is asserted mid-operation, and SHALL ignore ld_i during reset.

Structure
REQ-033 SHALL place WID, SHW and the tag width (4) as constants in a shared package, fpu_align_pkg.
REQ-034 SHALL instantiate exactly one sub-module, redor32 (5-bit index, 32-bit data, prefix OR), in S2.
REQ-035 SHALL compute the S2 result combinationally from the S1 registers and register it into the output registers on advance.

Verification
REQ-036 SHALL cover: b=0x0000_00F0, a=4, ack held 1 -> 2 cycles later o=0x0000_000F, sticky=0.
REQ-037 SHALL cover: b=0x0000_00F8, a=4 -> o=0x0000_000F, sticky=1; then a=0 with b=0xFFFF_FFFF -> o=0xFFFF_FFFF, sticky=0.
REQ-038 SHALL cover: b=0x8000_0001, a=32 -> o=0, sticky=1; then b=0, a=63 -> o=0, sticky=0.
REQ-039 SHALL cover: ack=0 with 3 back-to-back loads (tags 1,2,3) -> rdy_o drops after 2 accepted; outputs hold tag 1; after ack=1, tags 1,2,3 arrive in order with none lost.
REQ-040 SHALL cover: 100 random transfers with ld/ack randomised -> every result matches a scoreboard model, in order.
REQ-041 SHALL cover: reset asserted with both stages full -> vld_o=0 the next cycle, rdy_o=1, and no stale result ever appears.

Source files
------------

// File: rtl/fpu_align_pkg.sv
// Shared constants and helpers for the 32-bit mantissa alignment shifter.
package fpu_align_pkg;
    localparam int WID  = 32;
    localparam int SHW  = 6;
    localparam int TAGW = 4;
    localparam int IDXW = 5;

    // Highest shifted-out bit index: a-1, clamped to 31 for shifts past the operand.
    function automatic logic [IDXW-1:0] sticky_idx(input logic [SHW-1:0] a);
        logic [IDXW-1:0] idx;
        if (a == '0) begin
            idx = '0;
        end else if (a[SHW-1]) begin
            idx = '1;
        end else begin
            idx = a[IDXW-1:0] - 5'd1;
        end
        return idx;
    endfunction
endpackage

// File: rtl/fpu_align_shift32_if.sv
// Valid/ready request and result bus of the alignment shifter.
interface fpu_align_shift32_if;
    logic                            ld_i;
    logic                            rdy_o;
    logic [fpu_align_pkg::SHW-1:0]   a_i;
    logic [fpu_align_pkg::WID-1:0]   b_i;
    logic [fpu_align_pkg::TAGW-1:0]  tag_i;
    logic                            vld_o;
    logic                            ack_i;
    logic [fpu_align_pkg::WID-1:0]   o_o;
    logic                            sticky_o;
    logic [fpu_align_pkg::TAGW-1:0]  tag_o;

    modport master (
        output ld_i, a_i, b_i, tag_i, ack_i,
        input  rdy_o, vld_o, o_o, sticky_o, tag_o
    );

    modport slave (
        input  ld_i, a_i, b_i, tag_i, ack_i,
        output rdy_o, vld_o, o_o, sticky_o, tag_o
    );
endinterface

// File: rtl/fpu_align_shift32_redor32.sv
// Prefix OR: OR of data_i[idx_i:0].
module redor32 (
    input  logic [4:0]  idx_i,
    input  logic [31:0] data_i,
    output logic        red_o
);
    logic [31:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < 32; i++) begin
            mask[i] = (5'(i) <= idx_i);
        end
        red_o = |(data_i & mask);
    end
endmodule

// File: rtl/fpu_align_shift32.sv
// Two-stage logical right shifter with sticky bit and valid/ready flow control.
module fpu_align_shift32 #(
    parameter int WID = 32,
    parameter int SHW = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fpu_align_shift32_if.slave  bus
);
    import fpu_align_pkg::*;

    logic             s1_v_q, s1_v_d;
    logic [SHW-1:0]   s1_a_q, s1_a_d;
    logic [WID-1:0]   s1_b_q, s1_b_d;
    logic [TAGW-1:0]  s1_tag_q, s1_tag_d;

    logic             s2_v_q, s2_v_d;
    logic [WID-1:0]   o_q, o_d;
    logic             sticky_q, sticky_d;
    logic [TAGW-1:0]  tag_q, tag_d;

    logic             rdy;
    logic             xfer;
    logic             adv;
    logic             consume;
    logic [WID-1:0]   shifted;
    logic             red;

    assign rdy     = !s1_v_q || !s2_v_q || bus.ack_i;
    assign xfer    = bus.ld_i && rdy;
    assign adv     = s1_v_q && (!s2_v_q || bus.ack_i);
    assign consume = s2_v_q && bus.ack_i;

    redor32 u_redor (
        .idx_i  (sticky_idx(s1_a_q)),
        .data_i (s1_b_q),
        .red_o  (red)
    );

    assign shifted = s1_a_q[SHW-1] ? '0 : (s1_b_q >> s1_a_q[IDXW-1:0]);

    always_comb begin
        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_tag_d = s1_tag_q;
        s2_v_d   = s2_v_q;
        o_d      = o_q;
        sticky_d = sticky_q;
        tag_d    = tag_q;

        if (xfer) begin
            s1_v_d   = 1'b1;
            s1_a_d   = bus.a_i;
            s1_b_d   = bus.b_i;
            s1_tag_d = bus.tag_i;
        end else if (adv) begin
            s1_v_d   = 1'b0;
        end

        // Output registers only change on advance, so they hold under backpressure.
        if (adv) begin
            s2_v_d   = 1'b1;
            o_d      = shifted;
            sticky_d = (s1_a_q != '0) && red;
            tag_d    = s1_tag_q;
        end else if (consume) begin
            s2_v_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            o_q      <= '0;
            sticky_q <= 1'b0;
            tag_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_tag_q <= s1_tag_d;
            s2_v_q   <= s2_v_d;
            o_q      <= o_d;
            sticky_q <= sticky_d;
            tag_q    <= tag_d;
        end
    end

    assign bus.rdy_o    = rdy;
    assign bus.vld_o    = s2_v_q;
    assign bus.o_o      = o_q;
    assign bus.sticky_o = sticky_q;
    assign bus.tag_o    = tag_q;
endmodule

// File: tb/tb_fpu_align_shift32.sv
// Directed and randomised checks of the alignment shifter against a reference shift model.
module tb_fpu_align_shift32;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   failures = 0;

    typedef struct packed {
        logic [31:0] o;
        logic        s;
        logic [3:0]  t;
    } exp_t;

    fpu_align_shift32_if bus ();

    fpu_align_shift32 #(.WID(32), .SHW(6)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t model(input logic [5:0] a, input logic [31:0] b, input logic [3:0] t);
        exp_t e;
        e.o = (a >= 6'd32) ? 32'h0 : (b >> a);
        e.s = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(a)) e.s = e.s | b[i];
        end
        e.t = t;
        return e;
    endfunction

    task automatic drive(input logic ld, input logic [5:0] a, input logic [31:0] b,
                         input logic [3:0] t, input logic ack);
        bus.ld_i  = ld;
        bus.a_i   = a;
        bus.b_i   = b;
        bus.tag_i = t;
        bus.ack_i = ack;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1'b1, 6'd4, 32'hF0, 4'd9, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b0, 6'd0, 32'h0, 4'd0, 1'b0);
        #1;
        checks++;
        if (bus.vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", bus.vld_o); end
        checks++;
        if (bus.rdy_o !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", bus.rdy_o); end
        @(negedge clk_i); #1;
        checks++;
        if (bus.vld_o !== 1'b0) begin failures++; $display("FAIL reset_ld_ignored got=%b exp=0", bus.vld_o); end
    endtask

    task automatic test_directed();
        logic [5:0]  va [8] = '{6'd4, 6'd4, 6'd0, 6'd32, 6'd63, 6'd31, 6'd1, 6'd31};
        logic [31:0] vb [8] = '{32'h0000_00F0, 32'h0000_00F8, 32'hFFFF_FFFF, 32'h8000_0001,
                                32'h0, 32'h8000_0000, 32'h3, 32'h4000_0000};
        logic [31:0] vo [8] = '{32'h0000_000F, 32'h0000_000F, 32'hFFFF_FFFF, 32'h0,
                                32'h0, 32'h1, 32'h1, 32'h0};
        logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            drive(1'b1, va[k], vb[k], 4'(k), 1'b1);
            #1;
            checks++;
            if (bus.rdy_o !== 1'b1) begin failures++; $display("FAIL dir%0d_rdy got=%b exp=1", k, bus.rdy_o); end
            @(negedge clk_i);
            drive(1'b0, 6'd0, 32'h0, 4'd0, 1'b1);
            #1;
            checks++;
            if (bus.vld_o !== 1'b0) begin failures++; $display("FAIL dir%0d_early got=%b exp=0", k, bus.vld_o); end
            @(negedge clk_i); #1;
            checks++;
            if (bus.vld_o !== 1'b1 || bus.o_o !== vo[k] || bus.sticky_o !== vs[k] || bus.tag_o !== 4'(k)) begin
                failures++;
                $display("FAIL dir%0d_result got vld=%b o=%h s=%b t=%0d exp vld=1 o=%h s=%b t=%0d",
                         k, bus.vld_o, bus.o_o, bus.sticky_o, bus.tag_o, vo[k], vs[k], k);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (c < 6) drive(1'b1, 6'(c * 7), 32'hA5C3_0F96 + 32'(c), 4'(c + 1), 1'b1);
            else       drive(1'b0, 6'd0, 32'h0, 4'd0, 1'b1);
            #1;
            if (c >= 2) begin
                e = model(6'((c - 2) * 7), 32'hA5C3_0F96 + 32'(c - 2), 4'(c - 1));
                checks++;
                if (bus.vld_o !== 1'b1 || bus.o_o !== e.o || bus.sticky_o !== e.s || bus.tag_o !== e.t) begin
                    failures++;
                    $display("FAIL b2b%0d got vld=%b o=%h s=%b t=%0d exp vld=1 o=%h s=%b t=%0d",
                             c, bus.vld_o, bus.o_o, bus.sticky_o, bus.tag_o, e.o, e.s, e.t);
                end
            end
        end
        @(negedge clk_i); #1;
        checks++;
        if (bus.vld_o !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", bus.vld_o); end
    endtask

    task automatic test_backpressure();
        @(negedge clk_i);
        drive(1'b1, 6'd4, 32'h100, 4'd1, 1'b0);
        #1;
        checks++;
        if (bus.rdy_o !== 1'b1) begin failures++; $display("FAIL bp_rdy1 got=%b exp=1", bus.rdy_o); end
        @(negedge clk_i);
        drive(1'b1, 6'd4, 32'h200, 4'd2, 1'b0);
        #1;
        checks++;
        if (bus.rdy_o !== 1'b1) begin failures++; $display("FAIL bp_rdy2 got=%b exp=1", bus.rdy_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            drive(1'b1, 6'd4, 32'h300, 4'd3, 1'b0);
            #1;
            checks++;
            if (bus.rdy_o !== 1'b0) begin failures++; $display("FAIL bp_full%0d_rdy got=%b exp=0", k, bus.rdy_o); end
            checks++;
            if (bus.vld_o !== 1'b1 || bus.tag_o !== 4'd1 || bus.o_o !== 32'h10 || bus.sticky_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got vld=%b t=%0d o=%h s=%b exp vld=1 t=1 o=10 s=0",
                         k, bus.vld_o, bus.tag_o, bus.o_o, bus.sticky_o);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            if (k == 1) drive(1'b1, 6'd4, 32'h300, 4'd3, 1'b1);
            else        drive(1'b0, 6'd0, 32'h0, 4'd0, 1'b1);
            #1;
            checks++;
            if (k <= 3) begin
                if (bus.vld_o !== 1'b1 || bus.tag_o !== 4'(k) || bus.o_o !== 32'(k) << 4) begin
                    failures++;
                    $display("FAIL bp_drain%0d got vld=%b t=%0d o=%h exp vld=1 t=%0d o=%h",
                             k, bus.vld_o, bus.tag_o, bus.o_o, k, 32'(k) << 4);
                end
            end else if (bus.vld_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_extra got vld=%b exp=0", bus.vld_o);
            end
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e, held;
        logic hold_prev = 1'b0;
        logic ld, ack;
        int   sent = 0;
        int   cyc = 0;
        while (cyc < 4000 && (sent < 100 || q.size() != 0)) begin
            @(negedge clk_i);
            ld  = (sent < 100) && ($urandom_range(0, 9) < 7);
            ack = (sent >= 100) || ($urandom_range(0, 9) < 6);
            drive(ld, 6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)), ack);
            #1;
            if (hold_prev) begin
                checks++;
                if (bus.vld_o !== 1'b1 || bus.o_o !== held.o || bus.sticky_o !== held.s || bus.tag_o !== held.t) begin
                    failures++;
                    $display("FAIL rnd_hold cyc=%0d got vld=%b o=%h s=%b t=%0d exp vld=1 o=%h s=%b t=%0d",
                             cyc, bus.vld_o, bus.o_o, bus.sticky_o, bus.tag_o, held.o, held.s, held.t);
                end
            end
            hold_prev = bus.vld_o && !ack;
            held = '{o: bus.o_o, s: bus.sticky_o, t: bus.tag_o};
            if (bus.vld_o && ack) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_unexpected cyc=%0d got t=%0d exp none", cyc, bus.tag_o);
                end else begin
                    e = q.pop_front();
                    if (bus.o_o !== e.o || bus.sticky_o !== e.s || bus.tag_o !== e.t) begin
                        failures++;
                        $display("FAIL rnd_result cyc=%0d got o=%h s=%b t=%0d exp o=%h s=%b t=%0d",
                                 cyc, bus.o_o, bus.sticky_o, bus.tag_o, e.o, e.s, e.t);
                    end
                end
            end
            if (ld && bus.rdy_o) begin
                q.push_back(model(bus.a_i, bus.b_i, bus.tag_i));
                sent++;
            end
            cyc++;
        end
        checks++;
        if (sent != 100 || q.size() != 0) begin
            failures++;
            $display("FAIL rnd_timeout got sent=%0d pending=%0d exp sent=100 pending=0", sent, q.size());
        end
        @(negedge clk_i);
        drive(1'b0, 6'd0, 32'h0, 4'd0, 1'b1);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk_i);
        drive(1'b1, 6'd1, 32'h3, 4'd5, 1'b0);
        @(negedge clk_i);
        drive(1'b1, 6'd1, 32'h5, 4'd6, 1'b0);
        @(negedge clk_i); #1;
        checks++;
        if (bus.vld_o !== 1'b1 || bus.rdy_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_full got vld=%b rdy=%b exp vld=1 rdy=0", bus.vld_o, bus.rdy_o);
        end
        rst_i = 1'b1;
        drive(1'b1, 6'd1, 32'h7, 4'd7, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b0, 6'd0, 32'h0, 4'd0, 1'b0);
        #1;
        checks++;
        if (bus.vld_o !== 1'b0 || bus.rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got vld=%b rdy=%b exp vld=0 rdy=1", bus.vld_o, bus.rdy_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            drive(1'b0, 6'd0, 32'h0, 4'd0, 1'b1);
            #1;
            checks++;
            if (bus.vld_o !== 1'b0) begin failures++; $display("FAIL mid_stale%0d got vld=%b exp=0", k, bus.vld_o); end
        end
    endtask

    initial begin
        drive(1'b0, 6'd0, 32'h0, 4'd0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
